// File: rtl/sync_sequencer.sv
// sync_sequencer: master H/V timing for the video chain. Owns the line and frame
// counters, decodes hreset/vreset, and keeps the H/V blank latches plus the
// active-low sync pulses derived from them. Pixel advance is qualified by clk_en;
// the blank latches update on every mclk edge.
module sync_sequencer #(
  parameter int H_TOTAL = 455,
  parameter int V_TOTAL = 262,
  parameter int HB_END  = 80
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       clk_en,
  output logic [8:0] hcount,
  output logic [8:0] vcount,
  output logic       hreset,
  output logic       vreset,
  output logic       hblank,
  output logic       _hblank,
  output logic       vblank,
  output logic       _vblank,
  output logic       _hsync,
  output logic       _vsync
);

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] HB_CLR = 9'(HB_END);

  // Counters are 9 bits wide; the blank-clear decode must land inside the line
  // and vblank clears on vcount[4], so a frame needs at least 17 lines.
  generate
    if (H_TOTAL > 512 || H_TOTAL < HB_END + 1 || HB_END < 0) begin : g_bad_h
      $error("sync_sequencer: H_TOTAL/HB_END out of range");
    end
    if (V_TOTAL > 512 || V_TOTAL < 17) begin : g_bad_v
      $error("sync_sequencer: V_TOTAL out of range");
    end
  endgenerate

  // End-of-line / end-of-frame decodes from the registered counters; each is
  // held for the whole clk_en period in which the counter sits at its last value.
  assign hreset = (hcount == H_LAST);
  assign vreset = hreset && (vcount == V_LAST);

  // Pixel and line counters; both wrap on the same edge at end of frame.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (clk_en) begin
      if (hreset) begin
        hcount <= '0;
        if (vreset) begin
          vcount <= '0;
        end else begin
          vcount <= vcount + 9'd1;
        end
      end else begin
        hcount <= hcount + 9'd1;
      end
    end
  end

  // Horizontal blank latch: set on the last pixel of a line, cleared at HB_END.
  // Not qualified by clk_en, so it follows the decode one mclk later.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      hblank <= 1'b1;
    end else if (hreset) begin
      hblank <= 1'b1;
    end else if (hcount == HB_CLR) begin
      hblank <= 1'b0;
    end
  end

  // Vertical blank latch: set on the last pixel of the frame, cleared once the
  // line count reaches 16 (vcount[4]); set wins if both are present.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      vblank <= 1'b1;
    end else if (vreset) begin
      vblank <= 1'b1;
    end else if (vcount[4]) begin
      vblank <= 1'b0;
    end
  end

  // Complements and sync pulses are pure decodes of registered state.
  assign _hblank = ~hblank;
  assign _vblank = ~vblank;
  assign _hsync  = ~(hblank & hcount[5] & ~hcount[6]);
  assign _vsync  = ~(vblank & vcount[2] & ~vcount[3]);

endmodule

// File: tb/tb_sync_sequencer.sv
// Bench for sync_sequencer: a default-size instance plus a small-frame instance
// (so whole frames wrap quickly), both checked every cycle against a model that
// tracks the clk_en pulse count since reset and derives counters arithmetically.
module tb_sync_sequencer;

  logic mclk = 1'b0;
  logic reset = 1'b1;
  logic clk_en = 1'b0;

  logic [8:0] hc0, vc0, hc1, vc1;
  logic hr0, vr0, hb0, hbn0, vb0, vbn0, hs0, vs0;
  logic hr1, vr1, hb1, hbn1, vb1, vbn1, hs1, vs1;

  always #5 mclk = ~mclk;

  sync_sequencer dut0 (
    .mclk(mclk), .reset(reset), .clk_en(clk_en),
    .hcount(hc0), .vcount(vc0), .hreset(hr0), .vreset(vr0),
    .hblank(hb0), ._hblank(hbn0), .vblank(vb0), ._vblank(vbn0),
    ._hsync(hs0), ._vsync(vs0)
  );

  sync_sequencer #(.H_TOTAL(100), .V_TOTAL(20), .HB_END(40)) dut1 (
    .mclk(mclk), .reset(reset), .clk_en(clk_en),
    .hcount(hc1), .vcount(vc1), .hreset(hr1), .vreset(vr1),
    .hblank(hb1), ._hblank(hbn1), .vblank(vb1), ._vblank(vbn1),
    ._hsync(hs1), ._vsync(vs1)
  );

  localparam int HT [2] = '{455, 100};
  localparam int VT [2] = '{262, 20};
  localparam int HB [2] = '{80, 40};

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  // model state: pixel pulses since reset (mod frame) and the two blank latches
  int p [2];
  bit mhb [2];
  bit mvb [2];

  // model update: blank latches react to the pre-edge position, position advances on clk_en
  always @(posedge mclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        p[i]   <= 0;
        mhb[i] <= 1'b1;
        mvb[i] <= 1'b1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int h, v;
        h = p[i] % HT[i];
        v = (p[i] / HT[i]) % VT[i];
        if (h == HT[i] - 1) mhb[i] <= 1'b1;
        else if (h == HB[i]) mhb[i] <= 1'b0;
        if (h == HT[i] - 1 && v == VT[i] - 1) mvb[i] <= 1'b1;
        else if ((v / 16) % 2 == 1) mvb[i] <= 1'b0;
        if (clk_en) p[i] <= (p[i] + 1) % (HT[i] * VT[i]);
      end
    end
  end

  function automatic logic [25:0] expv(int i);
    int h, v;
    bit hr, vr, hs, vs;
    h  = p[i] % HT[i];
    v  = (p[i] / HT[i]) % VT[i];
    hr = (h == HT[i] - 1);
    vr = hr && (v == VT[i] - 1);
    hs = !(mhb[i] && ((h / 32) % 4 == 1));
    vs = !(mvb[i] && ((v / 4) % 4 == 1));
    return {9'(h), 9'(v), hr, vr, mhb[i], !mhb[i], mvb[i], !mvb[i], hs, vs};
  endfunction

  task automatic cmp(string n, logic [25:0] a, logic [25:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", n, $time, a, e);
    end
  endtask

  task automatic check(string n, int a, int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", n, $time, a, e);
    end
  endtask

  // per-cycle compare of both instances against the model
  always @(negedge mclk) begin
    #2;
    if (chk_on) begin
      cmp("cyc_dut0", {hc0, vc0, hr0, vr0, hb0, hbn0, vb0, vbn0, hs0, vs0}, expv(0));
      cmp("cyc_dut1", {hc1, vc1, hr1, vr1, hb1, hbn1, vb1, vbn1, hs1, vs1}, expv(1));
    end
  end

  // advance until the selected instance shows (h, v); v < 0 matches any line.
  // With alt set, clk_en toggles every mclk.
  task automatic wait_for(int sel, int h, int v, int budget, bit alt, output int cyc);
    bit found;
    int ch, cv;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < budget) begin
      @(negedge mclk);
      if (alt) clk_en = ~clk_en;
      #2;
      cyc++;
      ch = sel ? int'(hc1) : int'(hc0);
      cv = sel ? int'(vc1) : int'(vc0);
      if (ch == h && (v < 0 || cv == v)) found = 1'b1;
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL wait_dut%0d_h%0d_v%0d timeout got h=%0d v=%0d", sel, h, v, ch, cv);
    end
  endtask

  task automatic step();
    @(negedge mclk);
    #2;
  endtask

  initial begin
    int c, c1, c2;
    reset = 1'b1;
    clk_en = 1'b0;
    repeat (3) @(negedge mclk);
    #2;
    chk_on = 1'b1;
    check("rst_hcount", hc0, 0);
    check("rst_vcount", vc0, 0);
    check("rst_hblank", hb0, 1);
    check("rst_n_hblank", hbn0, 0);
    check("rst_vblank", vb0, 1);
    check("rst_n_vblank", vbn0, 0);
    check("rst_hsync", hs0, 1);
    check("rst_vsync", vs0, 1);
    check("rst_hreset", hr0, 0);
    check("rst_vreset", vr0, 0);

    // released with clk_en low: everything frozen, then one pulse -> hcount 1
    @(negedge mclk);
    reset = 1'b0;
    repeat (100) @(negedge mclk);
    #2;
    check("frozen_hcount", hc0, 0);
    check("frozen_hblank", hb0, 1);
    check("frozen_vblank", vb0, 1);
    @(negedge mclk);
    clk_en = 1'b1;
    @(negedge mclk);
    clk_en = 1'b0;
    #2;
    check("first_pulse_hcount", hc0, 1);

    // continuous clk_en
    clk_en = 1'b1;
    wait_for(0, 454, 0, 1000, 1'b0, c);
    check("hreset_at_454", hr0, 1);
    check("no_vreset_line0", vr0, 0);
    step();
    check("wrap_hcount", hc0, 0);
    check("wrap_vcount", vc0, 1);
    check("hblank_line_start", hb0, 1);
    check("hreset_off", hr0, 0);
    wait_for(0, 80, -1, 1000, 1'b0, c);
    check("hblank_at_80", hb0, 1);
    step();
    check("hblank_clear_81", hb0, 0);
    wait_for(0, 454, -1, 1000, 1'b0, c);
    wait_for(0, 454, -1, 1000, 1'b0, c);
    check("line_period", c, 455);

    // sync windows
    wait_for(0, 454, 3, 3000, 1'b0, c);
    check("vsync_line3", vs0, 1);
    step();
    check("vsync_line4", vs0, 0);
    wait_for(0, 40, 4, 1000, 1'b0, c);
    check("hsync_h40", hs0, 0);
    wait_for(0, 70, 4, 1000, 1'b0, c);
    check("hsync_h70", hs0, 1);
    wait_for(0, 31, 5, 1000, 1'b0, c);
    check("hsync_h31", hs0, 1);
    step();
    check("hsync_h32", hs0, 0);
    wait_for(0, 63, 5, 1000, 1'b0, c);
    check("hsync_h63", hs0, 0);
    step();
    check("hsync_h64", hs0, 1);
    wait_for(0, 0, 8, 2000, 1'b0, c);
    check("vsync_line8", vs0, 1);
    wait_for(0, 0, 16, 4000, 1'b0, c);
    check("vblank_line16_h0", vb0, 1);
    step();
    check("vblank_line16_h1", vb0, 0);
    check("n_vblank_line16_h1", vbn0, 1);

    // small-frame instance: frame wrap
    wait_for(1, 99, 19, 2500, 1'b0, c);
    check("small_vreset", vr1, 1);
    step();
    check("small_wrap_h", hc1, 0);
    check("small_wrap_v", vc1, 0);
    check("small_vblank_set", vb1, 1);

    // clk_en one-in-two
    wait_for(0, 5, -1, 2000, 1'b1, c);
    wait_for(0, 4, -1, 2000, 1'b1, c1);
    wait_for(0, 5, -1, 2000, 1'b1, c2);
    check("alt_line_period", c1 + c2, 910);
    wait_for(0, 81, -1, 2000, 1'b1, c);
    check("alt_hblank_81", hb0, 0);
    wait_for(0, 0, -1, 2000, 1'b1, c);
    check("alt_hblank_h0", hb0, 1);

    // reset mid-frame
    clk_en = 1'b1;
    wait_for(0, 200, 100, 50000, 1'b0, c);
    reset = 1'b1;
    #1;
    check("midrst_hcount", hc0, 0);
    check("midrst_vcount", vc0, 0);
    check("midrst_hblank", hb0, 1);
    check("midrst_vblank", vb0, 1);
    check("midrst_hsync", hs0, 1);
    check("midrst_vsync", vs0, 1);
    check("midrst_small_h", hc1, 0);
    @(negedge mclk);
    @(negedge mclk);
    reset = 1'b0;
    step();
    check("post_rst_hcount", hc0, 1);
    check("post_rst_vcount", vc0, 0);
    check("post_rst_hblank", hb0, 1);
    check("post_rst_vblank", vb0, 1);
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
